// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : N-port memory bus arbiter with fixed or round-robin selection,
//            request lock under back-pressure and in-order read response routing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_DEPTH   = 4,
    parameter int RR_MODE    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             port_req_valid,
    output logic [NUM_PORTS-1:0]             port_req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_req_addr,
    input  logic [NUM_PORTS-1:0]             port_req_wen,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_req_wdata,
    output logic [NUM_PORTS-1:0]             port_resp_valid,
    output logic [DATA_WIDTH-1:0]            port_resp_rdata,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic                             mem_req_wen,
    output logic [DATA_WIDTH-1:0]            mem_req_wdata,
    input  logic                             mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]            mem_resp_rdata,
    output logic [$clog2(ID_DEPTH):0]        outstanding,
    output logic                             err_orphan
);

    localparam int c_id_w  = $clog2(NUM_PORTS);
    localparam int c_ptr_w = $clog2(ID_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_id_w-1:0]    r_fifo [ID_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_id_w-1:0]    r_rr_ptr;
    logic                 r_lock;
    logic [c_id_w-1:0]    r_lock_sel;
    logic [NUM_PORTS-1:0] r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                 r_err;

    logic                 w_full;
    logic [NUM_PORTS-1:0] w_elig;
    logic [c_id_w-1:0]    w_sel;
    logic                 w_any;
    int                   w_scan;
    logic                 w_active;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_PORTS-1:0] w_sel_onehot;

    assign w_full = (r_count == c_cnt_w'(ID_DEPTH));
    assign w_elig = port_req_valid & (port_req_wen | {NUM_PORTS{~w_full}});

    // A held lock wins outright; a dropped valid on the locked port falls through to a fresh scan.
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_scan = 0;
        if (r_lock && port_req_valid[r_lock_sel]) begin
            w_sel = r_lock_sel;
            w_any = 1'b1;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (RR_MODE != 0) begin
                    w_scan = int'(r_rr_ptr) + k;
                    if (w_scan >= NUM_PORTS) w_scan = w_scan - NUM_PORTS;
                end else begin
                    w_scan = k;
                end
                if (!w_any && w_elig[c_id_w'(w_scan)]) begin
                    w_sel = c_id_w'(w_scan);
                    w_any = 1'b1;
                end
            end
        end
    end

    // Request path is forced quiet while reset is asserted, even with requesters still valid.
    assign w_active     = rst_n & (|w_elig);
    assign w_accept     = w_active & mem_req_ready;
    assign w_push       = w_accept & ~port_req_wen[w_sel];
    assign w_pop        = mem_resp_valid & (r_count != '0);
    assign w_sel_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_sel;

    assign mem_req_valid  = w_active;
    assign mem_req_addr   = w_active ? port_req_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mem_req_wdata  = w_active ? port_req_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mem_req_wen    = w_active & port_req_wen[w_sel];
    assign port_req_ready = w_accept ? w_sel_onehot : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock       <= 1'b0;
            r_lock_sel   <= '0;
            r_rr_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_lock     <= w_active & ~mem_req_ready;
            r_lock_sel <= w_sel;
            if (w_accept) begin
                r_rr_ptr <= (w_sel == c_id_w'(NUM_PORTS - 1)) ? '0 : w_sel + 1'b1;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_resp_valid <= w_pop ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << r_fifo[r_rd_ptr]) : '0;
            if (w_pop) r_resp_rdata <= mem_resp_rdata;
            if (mem_resp_valid && (r_count == '0)) r_err <= 1'b1;
        end
    end

    assign port_resp_valid = r_resp_valid;
    assign port_resp_rdata = r_resp_rdata;
    assign outstanding     = r_count;
    assign err_orphan      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench; instance A is 3-port round-robin,
//            instance B is 4-port fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0]   a_valid, a_ready, a_wen, a_rvalid;
    logic [95:0]  a_addr, a_wdata;
    logic [31:0]  a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic         a_mvalid, a_mready, a_mwen, a_mrvalid, a_err;
    logic [2:0]   a_out;

    logic [3:0]   b_valid, b_ready, b_wen, b_rvalid;
    logic [127:0] b_addr, b_wdata;
    logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
    logic         b_mvalid, b_mready, b_mwen, b_mrvalid, b_err;
    logic [2:0]   b_out;

    mem_bus_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_DEPTH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .port_req_valid(a_valid), .port_req_ready(a_ready), .port_req_addr(a_addr),
        .port_req_wen(a_wen), .port_req_wdata(a_wdata),
        .port_resp_valid(a_rvalid), .port_resp_rdata(a_rdata),
        .mem_req_valid(a_mvalid), .mem_req_ready(a_mready), .mem_req_addr(a_maddr),
        .mem_req_wen(a_mwen), .mem_req_wdata(a_mwdata),
        .mem_resp_valid(a_mrvalid), .mem_resp_rdata(a_mrdata),
        .outstanding(a_out), .err_orphan(a_err)
    );

    mem_bus_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_DEPTH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .port_req_valid(b_valid), .port_req_ready(b_ready), .port_req_addr(b_addr),
        .port_req_wen(b_wen), .port_req_wdata(b_wdata),
        .port_resp_valid(b_rvalid), .port_resp_rdata(b_rdata),
        .mem_req_valid(b_mvalid), .mem_req_ready(b_mready), .mem_req_addr(b_maddr),
        .mem_req_wen(b_mwen), .mem_req_wdata(b_mwdata),
        .mem_resp_valid(b_mrvalid), .mem_resp_rdata(b_mrdata),
        .outstanding(b_out), .err_orphan(b_err)
    );

    function automatic logic [31:0] addr_of(input int p);
        return 32'hA000_0000 + 32'(p) * 32'h10;
    endfunction

    function automatic logic [31:0] wdata_of(input int p);
        return 32'h5A00_0000 + 32'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        if (a_out !== 3'd0) begin failures++; $display("FAIL reset_a_out got=%0d exp=0", a_out); end checks++;
        if (a_err !== 1'b0) begin failures++; $display("FAIL reset_a_err got=%0b exp=0", a_err); end checks++;
        if (a_rvalid !== 3'b000) begin failures++; $display("FAIL reset_a_rvalid got=%b exp=000", a_rvalid); end checks++;
        if (a_rdata !== 32'h0) begin failures++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end checks++;
        if (a_mvalid !== 1'b0) begin failures++; $display("FAIL reset_a_mvalid got=%b exp=0", a_mvalid); end checks++;
        if (b_out !== 3'd0) begin failures++; $display("FAIL reset_b_out got=%0d exp=0", b_out); end checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_alternate();
        logic [2:0] exp_sel [4];
        exp_sel = '{3'b001, 3'b010, 3'b001, 3'b010};
        tick();
        a_wen = 3'b000; a_valid = 3'b011; a_mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (a_ready !== exp_sel[i]) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, a_ready, exp_sel[i]); end checks++;
            if (a_maddr !== addr_of(i % 2)) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, a_maddr, addr_of(i % 2)); end checks++;
            tick();
        end
        a_valid = 3'b000;
        #1;
        if (a_out !== 3'd4) begin failures++; $display("FAIL rr_outstanding got=%0d exp=4", a_out); end checks++;
        for (int i = 0; i < 4; i++) begin
            a_mrvalid = 1'b1; a_mrdata = 32'hD000_0000 + 32'(i);
            tick();
            if (a_rvalid !== exp_sel[i]) begin failures++; $display("FAIL rr_resp_port[%0d] got=%b exp=%b", i, a_rvalid, exp_sel[i]); end checks++;
            if (a_rdata !== 32'hD000_0000 + 32'(i)) begin failures++; $display("FAIL rr_resp_data[%0d] got=%h exp=%h", i, a_rdata, 32'hD000_0000 + 32'(i)); end checks++;
        end
        a_mrvalid = 1'b0;
        tick();
        if (a_rvalid !== 3'b000) begin failures++; $display("FAIL rr_resp_pulse got=%b exp=000", a_rvalid); end checks++;
        if (a_rdata !== 32'hD000_0003) begin failures++; $display("FAIL rr_rdata_hold got=%h exp=d0000003", a_rdata); end checks++;
        if (a_out !== 3'd0) begin failures++; $display("FAIL rr_drained got=%0d exp=0", a_out); end checks++;
    endtask

    task automatic test_fixed_lock();
        tick();
        b_wen = 4'b1001; b_valid = 4'b1010; b_mready = 1'b0;
        #1;
        if (b_maddr !== addr_of(1)) begin failures++; $display("FAIL fp_first_addr got=%h exp=%h", b_maddr, addr_of(1)); end checks++;
        if (b_ready !== 4'b0000) begin failures++; $display("FAIL fp_stall_ready got=%b exp=0000", b_ready); end checks++;
        if (b_mvalid !== 1'b1) begin failures++; $display("FAIL fp_mvalid got=%b exp=1", b_mvalid); end checks++;
        tick();
        b_valid = 4'b1011;
        #1;
        if (b_maddr !== addr_of(1)) begin failures++; $display("FAIL fp_lock_addr got=%h exp=%h", b_maddr, addr_of(1)); end checks++;
        tick();
        if (b_maddr !== addr_of(1)) begin failures++; $display("FAIL fp_lock_addr2 got=%h exp=%h", b_maddr, addr_of(1)); end checks++;
        b_mready = 1'b1;
        #1;
        if (b_ready !== 4'b0010) begin failures++; $display("FAIL fp_lock_accept got=%b exp=0010", b_ready); end checks++;
        if (b_mwen !== 1'b0) begin failures++; $display("FAIL fp_lock_wen got=%b exp=0", b_mwen); end checks++;
        tick();
        #1;
        if (b_ready !== 4'b0001) begin failures++; $display("FAIL fp_p0_wins got=%b exp=0001", b_ready); end checks++;
        if (b_maddr !== addr_of(0)) begin failures++; $display("FAIL fp_p0_addr got=%h exp=%h", b_maddr, addr_of(0)); end checks++;
        if (b_mwen !== 1'b1) begin failures++; $display("FAIL fp_p0_wen got=%b exp=1", b_mwen); end checks++;
        if (b_mwdata !== wdata_of(0)) begin failures++; $display("FAIL fp_p0_wdata got=%h exp=%h", b_mwdata, wdata_of(0)); end checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            if (b_ready !== 4'b0001) begin failures++; $display("FAIL fp_starve[%0d] got=%b exp=0001", i, b_ready); end checks++;
        end
        b_valid = 4'b0000;
        tick();
        if (b_out !== 3'd1) begin failures++; $display("FAIL fp_outstanding got=%0d exp=1", b_out); end checks++;
        b_mrvalid = 1'b1; b_mrdata = 32'hBEEF_0001;
        tick();
        b_mrvalid = 1'b0;
        if (b_rvalid !== 4'b0010) begin failures++; $display("FAIL fp_resp_port got=%b exp=0010", b_rvalid); end checks++;
        if (b_rdata !== 32'hBEEF_0001) begin failures++; $display("FAIL fp_resp_data got=%h exp=beef0001", b_rdata); end checks++;
        tick();
        if (b_out !== 3'd0) begin failures++; $display("FAIL fp_drained got=%0d exp=0", b_out); end checks++;
    endtask

    task automatic test_fifo_full();
        tick();
        a_wen = 3'b000; a_valid = 3'b001; a_mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (a_ready !== 3'b001) begin failures++; $display("FAIL full_fill[%0d] got=%b exp=001", i, a_ready); end checks++;
            tick();
        end
        #1;
        if (a_out !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", a_out); end checks++;
        if (a_ready !== 3'b000) begin failures++; $display("FAIL full_blocked got=%b exp=000", a_ready); end checks++;
        if (a_mvalid !== 1'b0) begin failures++; $display("FAIL full_mvalid got=%b exp=0", a_mvalid); end checks++;
        a_valid = 3'b011; a_wen = 3'b010;
        #1;
        if (a_ready !== 3'b010) begin failures++; $display("FAIL full_write_ok got=%b exp=010", a_ready); end checks++;
        if (a_maddr !== addr_of(1)) begin failures++; $display("FAIL full_write_addr got=%h exp=%h", a_maddr, addr_of(1)); end checks++;
        if (a_mwdata !== wdata_of(1)) begin failures++; $display("FAIL full_write_data got=%h exp=%h", a_mwdata, wdata_of(1)); end checks++;
        tick();
        a_valid = 3'b001; a_wen = 3'b000; a_mrvalid = 1'b1; a_mrdata = 32'hC0DE_0001;
        #1;
        if (a_out !== 3'd4) begin failures++; $display("FAIL full_write_nofifo got=%0d exp=4", a_out); end checks++;
        if (a_ready !== 3'b000) begin failures++; $display("FAIL full_pop_cycle got=%b exp=000", a_ready); end checks++;
        tick();
        a_mrvalid = 1'b0;
        #1;
        if (a_rvalid !== 3'b001) begin failures++; $display("FAIL full_resp got=%b exp=001", a_rvalid); end checks++;
        if (a_out !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", a_out); end checks++;
        if (a_ready !== 3'b001) begin failures++; $display("FAIL full_fifth_read got=%b exp=001", a_ready); end checks++;
        tick();
        a_valid = 3'b000;
        if (a_out !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", a_out); end checks++;
        a_mrvalid = 1'b1; a_mrdata = 32'h5555_0004;
        repeat (4) tick();
        a_mrvalid = 1'b0;
        tick();
        if (a_out !== 3'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", a_out); end checks++;
    endtask

    task automatic test_orphan();
        a_mrvalid = 1'b1; a_mrdata = 32'hDEAD_DEAD;
        tick();
        a_mrvalid = 1'b0;
        #1;
        if (a_rvalid !== 3'b000) begin failures++; $display("FAIL orphan_rvalid got=%b exp=000", a_rvalid); end checks++;
        if (a_err !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", a_err); end checks++;
        if (a_rdata !== 32'h5555_0004) begin failures++; $display("FAIL orphan_rdata got=%h exp=55550004", a_rdata); end checks++;
        repeat (3) tick();
        if (a_err !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", a_err); end checks++;
    endtask

    task automatic test_reset_mid();
        a_wen = 3'b000; a_valid = 3'b001; a_mready = 1'b1;
        repeat (3) tick();
        a_valid = 3'b011; a_mready = 1'b0;
        tick();
        #1;
        if (a_out !== 3'd3) begin failures++; $display("FAIL rmid_count got=%0d exp=3", a_out); end checks++;
        if (a_maddr !== addr_of(1)) begin failures++; $display("FAIL rmid_locked got=%h exp=%h", a_maddr, addr_of(1)); end checks++;
        #1;
        rst_n = 1'b0;
        #1;
        if (a_mvalid !== 1'b0) begin failures++; $display("FAIL rmid_mvalid got=%b exp=0", a_mvalid); end checks++;
        if (a_maddr !== 32'h0) begin failures++; $display("FAIL rmid_maddr got=%h exp=0", a_maddr); end checks++;
        if (a_out !== 3'd0) begin failures++; $display("FAIL rmid_out got=%0d exp=0", a_out); end checks++;
        if (a_err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", a_err); end checks++;
        @(negedge clk);
        rst_n = 1'b1;
        a_mready = 1'b1;
        #1;
        if (a_ready !== 3'b001) begin failures++; $display("FAIL rmid_restart got=%b exp=001", a_ready); end checks++;
        a_valid = 3'b000;
        tick();
        a_mrvalid = 1'b1; a_mrdata = 32'h7777_7777;
        tick();
        a_mrvalid = 1'b0;
        if (a_err !== 1'b1) begin failures++; $display("FAIL rmid_late_resp got=%b exp=1", a_err); end checks++;
        if (a_rvalid !== 3'b000) begin failures++; $display("FAIL rmid_late_rvalid got=%b exp=000", a_rvalid); end checks++;
    endtask

    task automatic test_rr_wrap();
        tick();
        a_valid = 3'b100; a_wen = 3'b100; a_mready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (a_ready !== 3'b100) begin failures++; $display("FAIL wrap_p2[%0d] got=%b exp=100", i, a_ready); end checks++;
            tick();
        end
        a_valid = 3'b101; a_wen = 3'b101;
        #1;
        if (a_ready !== 3'b001) begin failures++; $display("FAIL wrap_p0_first got=%b exp=001", a_ready); end checks++;
        tick();
        #1;
        if (a_ready !== 3'b100) begin failures++; $display("FAIL wrap_p2_next got=%b exp=100", a_ready); end checks++;
        a_valid = 3'b000;
        tick();
    endtask

    initial begin
        a_valid = '0; a_wen = '0; a_mready = 1'b0; a_mrvalid = 1'b0; a_mrdata = '0;
        b_valid = '0; b_wen = '0; b_mready = 1'b0; b_mrvalid = 1'b0; b_mrdata = '0;
        for (int p = 0; p < 3; p++) begin
            a_addr[p*32 +: 32]  = addr_of(p);
            a_wdata[p*32 +: 32] = wdata_of(p);
        end
        for (int p = 0; p < 4; p++) begin
            b_addr[p*32 +: 32]  = addr_of(p);
            b_wdata[p*32 +: 32] = wdata_of(p);
        end
        test_reset();
        test_rr_alternate();
        test_fixed_lock();
        test_fifo_full();
        test_orphan();
        test_reset_mid();
        test_rr_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
